// File: rtl/quad_serializer.sv
// quad_serializer: captures four parallel 8-bit words and emits them as
// biased single-word beats over a valid/ready stream.
// Optional feature: define QUAD_SERIALIZER_CHECKSUM_EN to append a fifth
// beat carrying the mod-256 sum of the four biased words.
module quad_serializer #(
    parameter logic signed [3:0] BIAS  = -4'sd1,
    parameter bit                ORDER = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] y1,
    input  logic [7:0] y2,
    input  logic [7:0] y3,
    input  logic [7:0] y4,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [2:0] out_idx,
    output logic       out_last
);

`ifdef QUAD_SERIALIZER_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    // BIAS sign-extended to the data width; the add wraps mod 256
    localparam logic [7:0] BIAS_EXT = {{4{BIAS[3]}}, BIAS};

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       capture;
    logic [7:0] word_q [4];
    logic [7:0] biased [4];
    logic [1:0] sel;

    // State and beat counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Word holding registers; loaded only on the input handshake so upstream
    // changes during SEND cannot disturb the group in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                word_q[i] <= 8'h00;
            end
        end else if (capture) begin
            word_q[0] <= y1;
            word_q[1] <= y2;
            word_q[2] <= y3;
            word_q[3] <= y4;
        end
    end

    // Next-state logic: accept a group in IDLE, advance one beat per handshake in SEND
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Biased copies of the captured words
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            biased[i] = word_q[i] + BIAS_EXT;
        end
    end

`ifdef QUAD_SERIALIZER_CHECKSUM_EN
    logic [7:0] checksum;

    // Mod-256 sum of the four biased words for the trailing beat
    always_comb begin
        checksum = biased[0] + biased[1] + biased[2] + biased[3];
    end
`endif

    // Word select: ORDER=1 walks the words from y4 down to y1
    always_comb begin
        sel = ORDER ? ~cnt_q[1:0] : cnt_q[1:0];
    end

    // Outputs; beat fields are forced to zero outside SEND so reset and IDLE look clean
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == SEND);
        out_data  = 8'h00;
        out_idx   = 3'd0;
        out_last  = 1'b0;
        if (state_q == SEND) begin
            out_idx  = cnt_q;
            out_last = (cnt_q == LAST_IDX);
`ifdef QUAD_SERIALIZER_CHECKSUM_EN
            if (cnt_q == 3'd4) begin
                out_data = checksum;
            end else begin
                out_data = biased[sel];
            end
`else
            out_data = biased[sel];
`endif
        end
    end

endmodule

// File: doc/quad_serializer.md
QUAD_SERIALIZER -- requirements
Module: quad_serializer

Interface
REQ-001 The block SHALL have parameter BIAS, default -1 (signed 4-bit), added to every data word before output.
REQ-002 The block SHALL have parameter ORDER, default 0, where 0 selects y1..y4 emission order and 1 selects y4..y1.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the upstream four-word group is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept a group.
REQ-007 The block SHALL have ports y1, y2, y3, y4, input, 8 bits each, the four parallel words from the upstream parameterised stage.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning out_data holds a beat.
REQ-009 The block SHALL have port out_ready, input, 1 bit, the downstream acceptance signal.
REQ-010 The block SHALL have port out_data, output, 8 bits, the biased word of the current beat.
REQ-011 The block SHALL have port out_idx, output, 3 bits, the beat index within the group, starting at 0.
REQ-012 The block SHALL have port out_last, output, 1 bit, asserted with the final beat of a group.

Function
REQ-013 The block SHALL implement two states: IDLE, with in_ready=1 and out_valid=0, and SEND, with in_ready=0 and out_valid=1.
REQ-014 In IDLE, in_valid=1 SHALL capture y1..y4 into internal registers, clear the beat counter, and move to SEND on the same edge.
REQ-015 Each beat SHALL compute out_data = captured word + sign-extended BIAS, truncated mod 256 (for example, 0x00 with BIAS=-1 gives 0xFF).
REQ-016 With ORDER=0, beat k SHALL carry word y(k+1); with ORDER=1, beat k SHALL carry word y(4-k).
REQ-017 A beat SHALL complete only on a rising edge where out_valid=1 and out_ready=1; the counter then increments.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL remain stable.
REQ-019 Completion of the beat with out_last=1 SHALL return the block to IDLE; the next group can be accepted one cycle later at the earliest, giving no overlap.
REQ-020 Upstream changes to y1..y4 during SEND SHALL have no effect on the group in flight.
REQ-021 The first beat SHALL appear one cycle after the input handshake, and a group SHALL take at least 5 cycles from acceptance to return to IDLE (6 with the checksum beat).

Reset
REQ-022 Asserting resetn=0 SHALL immediately force IDLE, with in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, and cleared word registers, independent of clk.
REQ-023 A reset during SEND SHALL discard the in-flight group, and no partial beats SHALL follow the release of reset.
REQ-024 The first input handshake SHALL be possible on the first rising edge after resetn deasserts.

Configuration
REQ-025 When macro QUAD_SERIALIZER_CHECKSUM_EN is defined, each group SHALL emit a fifth beat at out_idx=4 with out_last=1, carrying the mod-256 sum of the four biased words.
REQ-026 Without QUAD_SERIALIZER_CHECKSUM_EN, a group SHALL be exactly four beats, out_last SHALL assert at out_idx=3, and out_idx SHALL never exceed 3.

Verification
REQ-027 Scenario: BIAS=-1, ORDER=0, y1..y4=0x10,0x20,0x00,0x7F, out_ready=1 -> out_data 0x0F,0x1F,0xFF,0x7E at out_idx 0..3, with out_last on idx 3.
REQ-028 Scenario: ORDER=1, same inputs -> out_data 0x7E,0xFF,0x1F,0x0F.
REQ-029 Scenario: out_ready held 0 for 3 cycles on beat 1 -> out_data=0x1F and out_idx=1 remain stable, and beat 2 follows one edge after out_ready rises.
REQ-030 Scenario: y inputs changed during SEND and in_valid held 1 -> the in-flight group is unchanged, in_ready=0 throughout, and the next group is captured only after out_last completes.
REQ-031 Scenario: resetn pulsed low at beat 2 -> out_valid=0 at once, in_ready=1, and no further beats from the old group.
REQ-032 Scenario: QUAD_SERIALIZER_CHECKSUM_EN defined, REQ-027 inputs -> a fifth beat with out_data=0xAB, out_idx=4 and out_last=1.
